// File: rtl/demux_stream.sv
// Registered 1:N packet demultiplexer with valid/ready on every port.
// The destination is locked on the first beat of a packet; every beat passes through one output register.
module demux_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i,
  input  logic             i_last,
  input  logic [SELW-1:0]  s,
  output logic [WIDTH-1:0] y,
  output logic [N-1:0]     y_valid,
  output logic             y_last,
  input  logic [N-1:0]     y_ready,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  localparam logic [SELW:0]   N_EXT   = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  state_t            state, state_d;
  logic              h_valid, h_last;
  logic [SELW-1:0]   h_dest;
  logic [WIDTH-1:0]  h_data;
  logic [SELW-1:0]   cur_dest, cur_dest_d;
  logic              cur_rr, cur_rr_d;
  logic [SELW-1:0]   rr_ptr;
  logic [SELW-1:0]   load_dest;
  logic              load, rr_adv, drop_inc;
  logic              drain, accept, s_bad;
  logic [SELW-1:0]   first_dest;
  logic [N-1:0]      hold_sel;

  // One-hot view of the held beat; drives both y_valid and the drain test.
  assign hold_sel   = h_valid ? (N'(1) << h_dest) : '0;
  assign y_valid    = hold_sel;
  assign y          = h_data;
  assign y_last     = h_last;
  assign drain      = |(hold_sel & y_ready);
  assign i_ready    = (state == DROP) || !h_valid || drain;
  assign accept     = i_valid && i_ready;
  assign s_bad      = ({1'b0, s} >= N_EXT);
  assign first_dest = mode ? rr_ptr : s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Packet framing: decides whether an accepted beat is loaded, dropped, or ends the packet.
  always_comb begin
    state_d    = state;
    load       = 1'b0;
    load_dest  = cur_dest;
    cur_dest_d = cur_dest;
    cur_rr_d   = cur_rr;
    rr_adv     = 1'b0;
    drop_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!mode && s_bad) begin
            drop_inc = 1'b1;
            if (!i_last) state_d = DROP;
          end else begin
            load       = 1'b1;
            load_dest  = first_dest;
            cur_dest_d = first_dest;
            cur_rr_d   = mode;
            if (i_last) rr_adv = mode;
            else        state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          load = 1'b1;
          if (i_last) begin
            rr_adv  = cur_rr;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept && i_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register, packet context and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid  <= 1'b0;
      h_dest   <= '0;
      h_data   <= '0;
      h_last   <= 1'b0;
      cur_dest <= '0;
      cur_rr   <= 1'b0;
      rr_ptr   <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (load) begin
        h_valid <= 1'b1;
        h_dest  <= load_dest;
        h_data  <= i;
        h_last  <= i_last;
      end else if (drain) begin
        h_valid <= 1'b0;
      end
      cur_dest <= cur_dest_d;
      cur_rr   <= cur_rr_d;
      if (rr_adv) rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + SELW'(1);
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: an N=4 and an N=3 instance driven by directed and random packets,
// compared every cycle against a packet-level reference model.
module tb_demux_stream;

  typedef struct {
    int         dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode, iv, il;
  logic [7:0] din[2];
  logic [1:0] sel[2];
  logic [3:0] yr[2];

  logic       iready_a, iready_b, ylast_a, ylast_b;
  logic [7:0] y_a, y_b, dc_a, dc_b;
  logic [3:0] yv_a;
  logic [2:0] yv_b;

  demux_stream #(.WIDTH(8), .N(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode[0]), .i_valid(iv[0]), .i_ready(iready_a),
    .i(din[0]), .i_last(il[0]), .s(sel[0]), .y(y_a), .y_valid(yv_a), .y_last(ylast_a),
    .y_ready(yr[0]), .drop_cnt(dc_a)
  );

  demux_stream #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode[1]), .i_valid(iv[1]), .i_ready(iready_b),
    .i(din[1]), .i_last(il[1]), .s(sel[1]), .y(y_b), .y_valid(yv_b), .y_last(ylast_b),
    .y_ready(yr[1][2:0]), .drop_cnt(dc_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: packet context and outstanding beats per instance.
  beat_t mq[2][$];
  bit    in_pkt[2], dropping[2], pkt_rr[2], acc[2];
  int    pkt_dest[2], rr[2], drops[2], rem[2];
  int    obs_ch[2][$], obs_cyc[2][$];
  logic [7:0] obs_dat[2][$];
  logic       obs_last[2][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] vout(int d);
    return (d != 0) ? {1'b0, yv_b} : yv_a;
  endfunction

  function automatic logic rdy(int d);
    return (d != 0) ? iready_b : iready_a;
  endfunction

  function automatic logic [7:0] yout(int d);
    return (d != 0) ? y_b : y_a;
  endfunction

  function automatic logic lout(int d);
    return (d != 0) ? ylast_b : ylast_a;
  endfunction

  function automatic logic [7:0] dcout(int d);
    return (d != 0) ? dc_b : dc_a;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      in_pkt[d] = 0; dropping[d] = 0; pkt_rr[d] = 0; acc[d] = 0;
      pkt_dest[d] = 0; rr[d] = 0; drops[d] = 0; rem[d] = 0;
    end
  endtask

  task automatic model_beat(input int d, input int n);
    beat_t b;
    if (!in_pkt[d]) begin
      in_pkt[d] = 1;
      if (!mode[d] && int'(sel[d]) >= n) begin
        dropping[d] = 1;
        drops[d] = (drops[d] < 255) ? drops[d] + 1 : 255;
      end else begin
        dropping[d] = 0;
        pkt_rr[d]   = mode[d];
        pkt_dest[d] = mode[d] ? rr[d] : int'(sel[d]);
      end
    end
    if (!dropping[d]) begin
      b.dest = pkt_dest[d]; b.data = din[d]; b.last = il[d];
      mq[d].push_back(b);
    end
    if (il[d]) begin
      if (!dropping[d] && pkt_rr[d]) rr[d] = (rr[d] + 1) % n;
      in_pkt[d] = 0;
      dropping[d] = 0;
    end
  endtask

  // Checks both instances mid-cycle, advances the model, and returns #1 after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int n;
      bit er, drn;
      logic [3:0] ev;
      n  = (d != 0) ? 3 : 4;
      er = dropping[d] || mq[d].size() == 0 || yr[d][mq[d][0].dest];
      check($sformatf("i_ready%0d", d), 32'(rdy(d)), 32'(er));
      ev = (mq[d].size() != 0) ? 4'(1 << mq[d][0].dest) : 4'd0;
      check($sformatf("y_valid%0d", d), 32'(vout(d)), 32'(ev));
      if (mq[d].size() != 0) begin
        check($sformatf("y%0d", d), 32'(yout(d)), 32'(mq[d][0].data));
        check($sformatf("y_last%0d", d), 32'(lout(d)), 32'(mq[d][0].last));
      end
      check($sformatf("drop_cnt%0d", d), 32'(dcout(d)), 32'(drops[d]));
      for (int k = 0; k < n; k++) begin
        if (vout(d)[k] && yr[d][k]) begin
          obs_ch[d].push_back(k);
          obs_dat[d].push_back(yout(d));
          obs_last[d].push_back(lout(d));
          obs_cyc[d].push_back(cyc);
        end
      end
      drn = (mq[d].size() != 0) && yr[d][mq[d][0].dest];
      acc[d] = iv[d] && er;
      if (drn) void'(mq[d].pop_front());
      if (acc[d]) model_beat(d, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic obs_clear();
    for (int d = 0; d < 2; d++) begin
      obs_ch[d].delete(); obs_dat[d].delete(); obs_last[d].delete(); obs_cyc[d].delete();
    end
  endtask

  task automatic send_beat(input int d, input logic m, input logic [7:0] data,
                           input logic last, input logic [1:0] s);
    mode[d] = m; din[d] = data; il[d] = last; sel[d] = s; iv[d] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (acc[d]) break;
    end
    if (!acc[d]) check("accept_timeout", 32'd0, 32'd1);
    iv[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    iv = 2'b00;
    repeat (n) cycle();
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_yv_a", 32'(yv_a), 32'd0);
    check("rst_y_a", 32'(y_a), 32'd0);
    check("rst_ylast_a", 32'(ylast_a), 32'd0);
    check("rst_dc_a", 32'(dc_a), 32'd0);
    check("rst_yv_b", 32'(yv_b), 32'd0);
    check("rst_dc_b", 32'(dc_b), 32'd0);
    iv = 2'b00;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    mode = '0; iv = '0; il = '0;
    for (int d = 0; d < 2; d++) begin
      din[d] = '0; sel[d] = '0; yr[d] = 4'hF;
    end
    model_clear();
    @(posedge clk);
    #1;
    async_reset();
    idle(1);

    // Addressed 3-beat packet to channel 2.
    obs_clear();
    send_beat(0, 1'b0, 8'h11, 1'b0, 2'd2);
    send_beat(0, 1'b0, 8'h22, 1'b0, 2'd0);
    send_beat(0, 1'b0, 8'h33, 1'b1, 2'd0);
    idle(2);
    check("addr_count", 32'(obs_ch[0].size()), 32'd3);
    if (obs_ch[0].size() == 3) begin
      check("addr_ch0", 32'(obs_ch[0][0]), 32'd2);
      check("addr_ch2", 32'(obs_ch[0][2]), 32'd2);
      check("addr_d0", 32'(obs_dat[0][0]), 32'h11);
      check("addr_d1", 32'(obs_dat[0][1]), 32'h22);
      check("addr_d2", 32'(obs_dat[0][2]), 32'h33);
      check("addr_last1", 32'(obs_last[0][1]), 32'd0);
      check("addr_last2", 32'(obs_last[0][2]), 32'd1);
      check("addr_span", 32'(obs_cyc[0][2] - obs_cyc[0][0]), 32'd2);
    end

    // Round-robin single-beat packets, then one more to expose the pointer.
    obs_clear();
    for (int k = 0; k < 5; k++) send_beat(0, 1'b1, 8'(8'hA0 + k), 1'b1, 2'd3);
    send_beat(0, 1'b1, 8'hA5, 1'b1, 2'd0);
    idle(2);
    check("rr_count", 32'(obs_ch[0].size()), 32'd6);
    if (obs_ch[0].size() == 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("rr_ch%0d", k), 32'(obs_ch[0][k]), 32'((k + 0) % 4 == 0 && k == 4 ? 0 : (k == 5 ? 1 : k)));
      check("rr_span", 32'(obs_cyc[0][4] - obs_cyc[0][0]), 32'd4);
    end

    // Backpressure on channel 1 during a 2-beat packet.
    obs_clear();
    yr[0] = 4'b1101;
    send_beat(0, 1'b0, 8'h5A, 1'b0, 2'd1);
    mode[0] = 1'b0; din[0] = 8'hC3; il[0] = 1'b1; sel[0] = 2'd2; iv[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("bp_stall", 32'(acc[0]), 32'd0);
      check("bp_hold", 32'(y_a), 32'h5A);
    end
    yr[0] = 4'hF;
    send_beat(0, 1'b0, 8'hC3, 1'b1, 2'd2);
    idle(2);
    check("bp_count", 32'(obs_dat[0].size()), 32'd2);
    if (obs_dat[0].size() == 2) begin
      check("bp_d0", 32'(obs_dat[0][0]), 32'h5A);
      check("bp_d1", 32'(obs_dat[0][1]), 32'hC3);
      check("bp_ch1", 32'(obs_ch[0][1]), 32'd1);
    end

    // Out-of-range destination on the N=3 instance, then a normal packet.
    obs_clear();
    send_beat(1, 1'b0, 8'h77, 1'b0, 2'd3);
    send_beat(1, 1'b0, 8'h78, 1'b1, 2'd0);
    idle(1);
    check("drop_cnt1", 32'(dc_b), 32'd1);
    check("drop_none", 32'(obs_ch[1].size()), 32'd0);
    send_beat(1, 1'b0, 8'h79, 1'b1, 2'd1);
    idle(2);
    check("drop_next_n", 32'(obs_ch[1].size()), 32'd1);
    if (obs_ch[1].size() == 1) check("drop_next_ch", 32'(obs_ch[1][0]), 32'd1);

    // Reset during beat 2 of 3 with beat 1 stuck in the output register.
    obs_clear();
    yr[0] = 4'b1101;
    send_beat(0, 1'b0, 8'h01, 1'b0, 2'd1);
    mode[0] = 1'b0; din[0] = 8'h02; il[0] = 1'b0; sel[0] = 2'd1; iv[0] = 1'b1;
    async_reset();
    yr[0] = 4'hF;
    idle(1);
    obs_clear();
    send_beat(0, 1'b0, 8'h99, 1'b1, 2'd3);
    idle(2);
    check("rst_next_n", 32'(obs_ch[0].size()), 32'd1);
    if (obs_ch[0].size() == 1) check("rst_next_ch", 32'(obs_ch[0][0]), 32'd3);

    // Random traffic on both instances.
    acc[0] = 0; acc[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (acc[d]) begin
          rem[d]--;
          iv[d] = 1'b0;
        end
        if (!iv[d]) begin
          if (rem[d] == 0) rem[d] = 1 + int'($urandom % 4);
          iv[d]   = ($urandom % 4) != 0;
          din[d]  = 8'($urandom);
          il[d]   = (rem[d] == 1);
          mode[d] = 1'($urandom);
          sel[d]  = 2'($urandom);
        end
        for (int k = 0; k < 4; k++) yr[d][k] = ($urandom % 4) != 0;
      end
      cycle();
    end
    yr[0] = 4'hF; yr[1] = 4'hF;
    idle(3);

    // Saturation of the drop counter.
    for (int k = 0; k < 260; k++) send_beat(1, 1'b0, 8'(k), 1'b1, 2'd3);
    idle(1);
    check("drop_sat", 32'(dc_b), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
